// File: rtl/age_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : age_issue_queue
//  Description : ALU issue queue with multi-port wake-up, oldest-ready select
//                by ROB age (relative to rob_head) and selective squash of
//                wrong-path uops younger than a mispredicted branch.
//  Revision    : 1.0 - initial release
// ============================================================================
module age_issue_queue #(
    parameter int IQ_SIZE       = 8,
    parameter int IQ_IDX_BITS   = 3,
    parameter int PHYS_REG_BITS = 6,
    parameter int ROB_IDX_BITS  = 4,
    parameter int NUM_WAKEUP    = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic                                  squash_en,
    input  logic [ROB_IDX_BITS-1:0]               squash_rob_idx,
    input  logic [ROB_IDX_BITS-1:0]               rob_head,
    input  logic                                  dispatch_en,
    input  logic [3:0]                            dispatch_alu_op,
    input  logic                                  dispatch_alu_src,
    input  logic [31:0]                           dispatch_imm,
    input  logic [PHYS_REG_BITS-1:0]              dispatch_phys_rs1,
    input  logic [PHYS_REG_BITS-1:0]              dispatch_phys_rs2,
    input  logic [PHYS_REG_BITS-1:0]              dispatch_phys_rd,
    input  logic                                  dispatch_src1_ready,
    input  logic                                  dispatch_src2_ready,
    input  logic [ROB_IDX_BITS-1:0]               dispatch_rob_idx,
    output logic                                  dispatch_ready,
    input  logic [NUM_WAKEUP-1:0]                 wakeup_en,
    input  logic [NUM_WAKEUP*PHYS_REG_BITS-1:0]   wakeup_phys_rd,
    output logic                                  issue_valid,
    output logic [3:0]                            issue_alu_op,
    output logic                                  issue_alu_src,
    output logic [31:0]                           issue_imm,
    output logic [PHYS_REG_BITS-1:0]              issue_phys_rs1,
    output logic [PHYS_REG_BITS-1:0]              issue_phys_rs2,
    output logic [PHYS_REG_BITS-1:0]              issue_phys_rd,
    output logic [ROB_IDX_BITS-1:0]               issue_rob_idx,
    input  logic                                  issue_ack,
    output logic [IQ_IDX_BITS:0]                  iq_count
);

    localparam int c_CNT_W = IQ_IDX_BITS + 1;

    // Per-slot state
    logic [IQ_SIZE-1:0]        r_valid;
    logic [IQ_SIZE-1:0]        r_src1_rdy;
    logic [IQ_SIZE-1:0]        r_src2_rdy;
    logic [3:0]                r_alu_op  [IQ_SIZE];
    logic                      r_alu_src [IQ_SIZE];
    logic [31:0]               r_imm     [IQ_SIZE];
    logic [PHYS_REG_BITS-1:0]  r_rs1     [IQ_SIZE];
    logic [PHYS_REG_BITS-1:0]  r_rs2     [IQ_SIZE];
    logic [PHYS_REG_BITS-1:0]  r_rd      [IQ_SIZE];
    logic [ROB_IDX_BITS-1:0]   r_rob     [IQ_SIZE];
    logic [c_CNT_W-1:0]        r_count;

    // Combinational helpers
    logic [IQ_SIZE-1:0]        w_ready;
    logic [IQ_SIZE-1:0]        w_squash_hit;
    logic [ROB_IDX_BITS-1:0]   w_age [IQ_SIZE];
    logic [ROB_IDX_BITS-1:0]   w_sq_age;
    logic [ROB_IDX_BITS-1:0]   w_best_age;
    logic [IQ_SIZE-1:0]        w_sel_oh;
    logic                      w_sel_found;
    logic [IQ_SIZE-1:0]        w_free_oh;
    logic                      w_free_found;
    logic                      w_issue_fire;
    logic                      w_disp_fire;
    logic [IQ_SIZE-1:0]        w_valid_nxt;
    logic [IQ_SIZE-1:0]        w_src1_nxt;
    logic [IQ_SIZE-1:0]        w_src2_nxt;
    logic [c_CNT_W-1:0]        w_count_nxt;

    // True when any enabled broadcast port carries a non-zero tag equal to tag
    function automatic logic f_woken(
        input logic [PHYS_REG_BITS-1:0]            tag,
        input logic [NUM_WAKEUP-1:0]               en,
        input logic [NUM_WAKEUP*PHYS_REG_BITS-1:0] tags
    );
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_WAKEUP; k++) begin
            if (en[k] && (tags[k*PHYS_REG_BITS +: PHYS_REG_BITS] != '0) &&
                (tags[k*PHYS_REG_BITS +: PHYS_REG_BITS] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Age is the modular distance from rob_head, so wrap-around compares correctly
    assign w_sq_age = squash_rob_idx - rob_head;

    genvar gi;
    for (gi = 0; gi < IQ_SIZE; gi++) begin : g_entry
        assign w_ready[gi]      = r_valid[gi] && r_src1_rdy[gi] && (r_src2_rdy[gi] || r_alu_src[gi]);
        assign w_age[gi]        = r_rob[gi] - rob_head;
        assign w_squash_hit[gi] = (w_age[gi] > w_sq_age);
    end

    // Oldest-ready select; strict less-than keeps the lowest slot on equal age
    always_comb begin
        w_sel_oh    = '0;
        w_sel_found = 1'b0;
        w_best_age  = '0;
        for (int i = 0; i < IQ_SIZE; i++) begin
            if (w_ready[i] && (!w_sel_found || (w_age[i] < w_best_age))) begin
                w_sel_oh    = '0;
                w_sel_oh[i] = 1'b1;
                w_sel_found = 1'b1;
                w_best_age  = w_age[i];
            end
        end
    end

    // Lowest-numbered free slot, from the registered valid vector only
    always_comb begin
        w_free_oh    = '0;
        w_free_found = 1'b0;
        for (int i = 0; i < IQ_SIZE; i++) begin
            if (!r_valid[i] && !w_free_found) begin
                w_free_oh[i] = 1'b1;
                w_free_found = 1'b1;
            end
        end
    end

    // Issue port fields, zero when nothing is selected
    always_comb begin
        issue_alu_op   = '0;
        issue_alu_src  = 1'b0;
        issue_imm      = '0;
        issue_phys_rs1 = '0;
        issue_phys_rs2 = '0;
        issue_phys_rd  = '0;
        issue_rob_idx  = '0;
        for (int i = 0; i < IQ_SIZE; i++) begin
            if (w_sel_oh[i]) begin
                issue_alu_op   = r_alu_op[i];
                issue_alu_src  = r_alu_src[i];
                issue_imm      = r_imm[i];
                issue_phys_rs1 = r_rs1[i];
                issue_phys_rs2 = r_rs2[i];
                issue_phys_rd  = r_rd[i];
                issue_rob_idx  = r_rob[i];
            end
        end
    end

    assign issue_valid    = w_sel_found;
    assign iq_count       = r_count;
    assign dispatch_ready = (r_count < c_CNT_W'(IQ_SIZE)) && !flush && !squash_en;
    assign w_issue_fire   = w_sel_found && issue_ack;
    assign w_disp_fire    = dispatch_en && dispatch_ready && w_free_found;

    // Next valid/ready vectors: issue and squash remove, dispatch inserts, flush wins
    always_comb begin
        w_valid_nxt = r_valid;
        w_src1_nxt  = r_src1_rdy;
        w_src2_nxt  = r_src2_rdy;
        w_count_nxt = '0;
        for (int i = 0; i < IQ_SIZE; i++) begin
            if (r_valid[i]) begin
                w_src1_nxt[i] = r_src1_rdy[i] | f_woken(r_rs1[i], wakeup_en, wakeup_phys_rd);
                w_src2_nxt[i] = r_src2_rdy[i] | f_woken(r_rs2[i], wakeup_en, wakeup_phys_rd);
            end
            if (w_issue_fire && w_sel_oh[i]) begin
                w_valid_nxt[i] = 1'b0;
            end
            if (squash_en && w_squash_hit[i]) begin
                w_valid_nxt[i] = 1'b0;
            end
            if (w_disp_fire && w_free_oh[i]) begin
                w_valid_nxt[i] = 1'b1;
                w_src1_nxt[i]  = dispatch_src1_ready |
                                 f_woken(dispatch_phys_rs1, wakeup_en, wakeup_phys_rd);
                w_src2_nxt[i]  = dispatch_src2_ready |
                                 f_woken(dispatch_phys_rs2, wakeup_en, wakeup_phys_rd);
            end
            if (flush) begin
                w_valid_nxt[i] = 1'b0;
            end
            w_count_nxt = w_count_nxt + c_CNT_W'(w_valid_nxt[i]);
        end
    end

    // Valid, ready and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= '0;
            r_src1_rdy <= '0;
            r_src2_rdy <= '0;
            r_count    <= '0;
        end else begin
            r_valid    <= w_valid_nxt;
            r_src1_rdy <= w_src1_nxt;
            r_src2_rdy <= w_src2_nxt;
            r_count    <= w_count_nxt;
        end
    end

    // Payload capture into the slot chosen for dispatch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IQ_SIZE; i++) begin
                r_alu_op[i]  <= '0;
                r_alu_src[i] <= 1'b0;
                r_imm[i]     <= '0;
                r_rs1[i]     <= '0;
                r_rs2[i]     <= '0;
                r_rd[i]      <= '0;
                r_rob[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < IQ_SIZE; i++) begin
                if (w_disp_fire && w_free_oh[i]) begin
                    r_alu_op[i]  <= dispatch_alu_op;
                    r_alu_src[i] <= dispatch_alu_src;
                    r_imm[i]     <= dispatch_imm;
                    r_rs1[i]     <= dispatch_phys_rs1;
                    r_rs2[i]     <= dispatch_phys_rs2;
                    r_rd[i]      <= dispatch_phys_rd;
                    r_rob[i]     <= dispatch_rob_idx;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_age_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_age_issue_queue
//  Description : Self-checking bench for age_issue_queue: directed scenarios
//                plus randomized traffic against a slot-array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_age_issue_queue;

    localparam int N  = 8;
    localparam int PB = 6;
    localparam int RB = 4;
    localparam int NW = 2;
    localparam int ROB_MOD = 1 << RB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          squash_en;
    logic [RB-1:0] squash_rob_idx;
    logic [RB-1:0] rob_head;
    logic          dispatch_en;
    logic [3:0]    dispatch_alu_op;
    logic          dispatch_alu_src;
    logic [31:0]   dispatch_imm;
    logic [PB-1:0] dispatch_phys_rs1, dispatch_phys_rs2, dispatch_phys_rd;
    logic          dispatch_src1_ready, dispatch_src2_ready;
    logic [RB-1:0] dispatch_rob_idx;
    wire           dispatch_ready;
    logic [NW-1:0] wakeup_en;
    logic [NW*PB-1:0] wakeup_phys_rd;
    wire           issue_valid;
    wire [3:0]     issue_alu_op;
    wire           issue_alu_src;
    wire [31:0]    issue_imm;
    wire [PB-1:0]  issue_phys_rs1, issue_phys_rs2, issue_phys_rd;
    wire [RB-1:0]  issue_rob_idx;
    logic          issue_ack;
    wire [3:0]     iq_count;

    age_issue_queue #(
        .IQ_SIZE(N), .IQ_IDX_BITS(3), .PHYS_REG_BITS(PB), .ROB_IDX_BITS(RB), .NUM_WAKEUP(NW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .squash_en(squash_en),
        .squash_rob_idx(squash_rob_idx), .rob_head(rob_head),
        .dispatch_en(dispatch_en), .dispatch_alu_op(dispatch_alu_op),
        .dispatch_alu_src(dispatch_alu_src), .dispatch_imm(dispatch_imm),
        .dispatch_phys_rs1(dispatch_phys_rs1), .dispatch_phys_rs2(dispatch_phys_rs2),
        .dispatch_phys_rd(dispatch_phys_rd), .dispatch_src1_ready(dispatch_src1_ready),
        .dispatch_src2_ready(dispatch_src2_ready), .dispatch_rob_idx(dispatch_rob_idx),
        .dispatch_ready(dispatch_ready), .wakeup_en(wakeup_en),
        .wakeup_phys_rd(wakeup_phys_rd), .issue_valid(issue_valid),
        .issue_alu_op(issue_alu_op), .issue_alu_src(issue_alu_src), .issue_imm(issue_imm),
        .issue_phys_rs1(issue_phys_rs1), .issue_phys_rs2(issue_phys_rs2),
        .issue_phys_rd(issue_phys_rd), .issue_rob_idx(issue_rob_idx),
        .issue_ack(issue_ack), .iq_count(iq_count)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: one record per slot
    bit            m_v   [N];
    bit            m_s1  [N];
    bit            m_s2  [N];
    logic [3:0]    m_op  [N];
    bit            m_src [N];
    logic [31:0]   m_imm [N];
    logic [PB-1:0] m_rs1 [N];
    logic [PB-1:0] m_rs2 [N];
    logic [PB-1:0] m_rd  [N];
    logic [RB-1:0] m_rob [N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h @%0t", tag, got, want, $time);
        end
    endtask

    function automatic int m_age(input logic [RB-1:0] x);
        return (int'(x) - int'(rob_head) + ROB_MOD) % ROB_MOD;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_v[i]);
        return c;
    endfunction

    function automatic int m_sel();
        int best = -1;
        for (int i = 0; i < N; i++) begin
            if (m_v[i] && m_s1[i] && (m_s2[i] || m_src[i])) begin
                if (best < 0 || m_age(m_rob[i]) < m_age(m_rob[best])) best = i;
            end
        end
        return best;
    endfunction

    function automatic bit m_woken(input logic [PB-1:0] t);
        logic [PB-1:0] w;
        for (int k = 0; k < NW; k++) begin
            w = wakeup_phys_rd[k*PB +: PB];
            if (wakeup_en[k] && t != 0 && w == t) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 0; m_s1[i] = 0; m_s2[i] = 0; m_op[i] = 0; m_src[i] = 0;
            m_imm[i] = 0; m_rs1[i] = 0; m_rs2[i] = 0; m_rd[i] = 0; m_rob[i] = 0;
        end
    endtask

    // Advance the model by one clock edge using the inputs held across that edge
    task automatic m_step();
        int sel, fr;
        bit dfire;
        sel   = m_sel();
        dfire = dispatch_en && (m_count() < N) && !flush && !squash_en;
        fr    = -1;
        for (int i = N - 1; i >= 0; i--) if (!m_v[i]) fr = i;
        if (flush) begin
            for (int i = 0; i < N; i++) m_v[i] = 0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (!m_v[i]) continue;
            if (issue_ack && i == sel) m_v[i] = 0;
            if (squash_en && m_age(m_rob[i]) > m_age(squash_rob_idx)) m_v[i] = 0;
            if (m_woken(m_rs1[i])) m_s1[i] = 1;
            if (m_woken(m_rs2[i])) m_s2[i] = 1;
        end
        if (dfire && fr >= 0) begin
            m_v[fr] = 1;
            m_s1[fr] = dispatch_src1_ready || m_woken(dispatch_phys_rs1);
            m_s2[fr] = dispatch_src2_ready || m_woken(dispatch_phys_rs2);
            m_op[fr] = dispatch_alu_op; m_src[fr] = dispatch_alu_src; m_imm[fr] = dispatch_imm;
            m_rs1[fr] = dispatch_phys_rs1; m_rs2[fr] = dispatch_phys_rs2;
            m_rd[fr] = dispatch_phys_rd; m_rob[fr] = dispatch_rob_idx;
        end
    endtask

    // Check outputs mid-cycle, then clock once and update the model
    task automatic cycle();
        int s;
        logic [63:0] want;
        #2;
        s = m_sel();
        chk("count", 64'(iq_count), 64'(m_count()));
        chk("dready", 64'(dispatch_ready), 64'((m_count() < N) && !flush && !squash_en));
        chk("ivalid", 64'(issue_valid), 64'(s >= 0));
        want = '0;
        if (s >= 0) want = {5'd0, m_op[s], m_src[s], m_imm[s], m_rs1[s], m_rs2[s], m_rd[s], m_rob[s]};
        chk("ifields", {5'd0, issue_alu_op, issue_alu_src, issue_imm, issue_phys_rs1,
                        issue_phys_rs2, issue_phys_rd, issue_rob_idx}, want);
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic idle();
        flush = 0; squash_en = 0; squash_rob_idx = 0; dispatch_en = 0;
        dispatch_alu_op = 0; dispatch_alu_src = 0; dispatch_imm = 0;
        dispatch_phys_rs1 = 0; dispatch_phys_rs2 = 0; dispatch_phys_rd = 0;
        dispatch_src1_ready = 0; dispatch_src2_ready = 0; dispatch_rob_idx = 0;
        wakeup_en = 0; wakeup_phys_rd = 0; issue_ack = 0;
    endtask

    task automatic set_disp(input int rob, input int rs1, input int rs2,
                            input bit r1, input bit r2, input bit src);
        dispatch_en = 1;
        dispatch_rob_idx = RB'(rob);
        dispatch_phys_rs1 = PB'(rs1); dispatch_phys_rs2 = PB'(rs2);
        dispatch_src1_ready = r1; dispatch_src2_ready = r2; dispatch_alu_src = src;
        dispatch_alu_op = 4'($urandom_range(0, 15));
        dispatch_imm = $urandom;
        dispatch_phys_rd = PB'($urandom_range(1, 63));
    endtask

    task automatic disp(input int rob, input int rs1, input int rs2,
                        input bit r1, input bit r2, input bit src);
        set_disp(rob, rs1, rs2, r1, r2, src);
        cycle();
        dispatch_en = 0;
    endtask

    task automatic do_flush();
        flush = 1;
        cycle();
        flush = 0;
    endtask

    logic [RB-1:0] exp_ord [3];

    initial begin
        idle();
        rob_head = 0;
        rst_n = 0;
        m_reset();
        #1;
        chk("rst0_count", 64'(iq_count), 0);
        chk("rst0_ivalid", 64'(issue_valid), 0);
        @(posedge clk); #1;
        rst_n = 1;
        cycle();

        // Reset in the middle of a cycle with five entries held
        for (int i = 0; i < 5; i++) disp(i, 20, 21, 0, 0, 0);
        chk("five_count", 64'(iq_count), 5);
        #2;
        rst_n = 0;
        #1;
        chk("rst_count", 64'(iq_count), 0);
        chk("rst_ivalid", 64'(issue_valid), 0);
        chk("rst_rob", 64'(issue_rob_idx), 0);
        m_reset();
        @(posedge clk); #1;
        rst_n = 1;
        #1;
        chk("rst_dready", 64'(dispatch_ready), 1);
        cycle();

        // Age select across ROB wrap
        rob_head = 14;
        disp(1, 0, 0, 1, 1, 0);
        disp(15, 0, 0, 1, 1, 0);
        disp(3, 0, 0, 1, 1, 0);
        exp_ord[0] = 4'd15; exp_ord[1] = 4'd1; exp_ord[2] = 4'd3;
        issue_ack = 1;
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("wrap_order", 64'(issue_rob_idx), 64'(exp_ord[j]));
            cycle();
        end
        issue_ack = 0;
        rob_head = 0;

        // Dual wake-up on two ports at once
        disp(0, 7, 9, 0, 0, 0);
        wakeup_en = 2'b11;
        wakeup_phys_rd = {6'd9, 6'd7};
        #1;
        chk("wk_before", 64'(issue_valid), 0);
        cycle();
        wakeup_en = 0;
        #1;
        chk("wk_after", 64'(issue_valid), 1);
        issue_ack = 1;
        cycle();
        issue_ack = 0;

        // Same-cycle dispatch bypass on rs1
        wakeup_en = 2'b01;
        wakeup_phys_rd = {6'd0, 6'd12};
        disp(1, 12, 0, 0, 0, 1);
        wakeup_en = 0;
        #1;
        chk("bypass", 64'(issue_valid), 1);
        issue_ack = 1;
        cycle();
        issue_ack = 0;

        // Tag zero never wakes
        disp(2, 0, 0, 0, 0, 1);
        wakeup_en = 2'b11;
        wakeup_phys_rd = '0;
        cycle();
        wakeup_en = 0;
        #1;
        chk("tag0", 64'(issue_valid), 0);
        do_flush();

        // Selective squash with a dropped dispatch
        disp(2, 30, 31, 0, 0, 0);
        disp(5, 30, 31, 0, 0, 0);
        disp(6, 30, 31, 0, 0, 0);
        disp(9, 30, 31, 0, 0, 0);
        squash_en = 1;
        squash_rob_idx = 5;
        set_disp(7, 0, 0, 1, 1, 0);
        #1;
        chk("sq_dready", 64'(dispatch_ready), 0);
        cycle();
        squash_en = 0;
        dispatch_en = 0;
        #1;
        chk("sq_count", 64'(iq_count), 2);
        do_flush();

        // Full queue, concurrent ack and dispatch, then refill
        for (int i = 0; i < N; i++) disp(i, 0, 0, 1, 1, 0);
        #1;
        chk("full_dready", 64'(dispatch_ready), 0);
        issue_ack = 1;
        set_disp(8, 0, 0, 1, 1, 0);
        cycle();
        issue_ack = 0;
        #1;
        chk("full_cnt7", 64'(iq_count), 7);
        chk("refill_dready", 64'(dispatch_ready), 1);
        cycle();
        dispatch_en = 0;
        #1;
        chk("refill_cnt", 64'(iq_count), 8);

        // Flush beats dispatch, issue and wake-up
        flush = 1;
        issue_ack = 1;
        set_disp(9, 3, 4, 0, 0, 0);
        wakeup_en = 2'b11;
        wakeup_phys_rd = {6'd3, 6'd4};
        cycle();
        idle();
        #1;
        chk("flush_count", 64'(iq_count), 0);
        chk("flush_ivalid", 64'(issue_valid), 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            idle();
            flush     = ($urandom_range(0, 99) < 2);
            squash_en = ($urandom_range(0, 99) < 6);
            squash_rob_idx = RB'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 10) rob_head = RB'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 65)
                set_disp($urandom_range(0, 15), $urandom_range(0, 12), $urandom_range(0, 12),
                         bit'($urandom_range(0, 99) < 30), bit'($urandom_range(0, 99) < 30),
                         bit'($urandom_range(0, 1)));
            for (int k = 0; k < NW; k++) begin
                wakeup_en[k] = ($urandom_range(0, 99) < 45);
                wakeup_phys_rd[k*PB +: PB] = PB'($urandom_range(0, 12));
            end
            issue_ack = ($urandom_range(0, 99) < 45);
            cycle();
        end
        idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
